// File: rtl/id_stage_pipe_if.sv
// Signal bundle for id_stage_pipe: IF/ID decode inputs, write-back port and ID/EX outputs.
// Flow control: if_valid offers an instruction; stall_out=1 means it was not taken this cycle
// and the producer must hold if_* unchanged; with stall_out=0 a valid instruction moves to EX on the edge.
interface id_stage_pipe_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            if_valid;
   logic [31:0]     if_inst;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_pc4;
   logic [2:0]      sext_op;
   logic            rf_we_in;
   logic            mem_rd_in;
   logic [1:0]      wd_sel_in;
   logic            flush;
   logic            wb_we;
   logic [AW-1:0]   wb_wr;
   logic [1:0]      wb_wd_sel;
   logic [XLEN-1:0] wb_alu_c;
   logic [XLEN-1:0] wb_dram_rd;
   logic [XLEN-1:0] wb_pc4;
   logic [XLEN-1:0] wb_ext;
   logic            stall_out;
   logic            ex_valid;
   logic            ex_rf_we;
   logic            ex_mem_rd;
   logic [1:0]      ex_wd_sel;
   logic [AW-1:0]   ex_wr;
   logic [XLEN-1:0] ex_rd1;
   logic [XLEN-1:0] ex_rd2;
   logic [XLEN-1:0] ex_ext;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_pc4;

   modport master (
      output if_valid, if_inst, if_pc, if_pc4, sext_op, rf_we_in, mem_rd_in, wd_sel_in,
             flush, wb_we, wb_wr, wb_wd_sel, wb_alu_c, wb_dram_rd, wb_pc4, wb_ext,
      input  stall_out, ex_valid, ex_rf_we, ex_mem_rd, ex_wd_sel, ex_wr,
             ex_rd1, ex_rd2, ex_ext, ex_pc, ex_pc4
   );

   modport slave (
      input  if_valid, if_inst, if_pc, if_pc4, sext_op, rf_we_in, mem_rd_in, wd_sel_in,
             flush, wb_we, wb_wr, wb_wd_sel, wb_alu_c, wb_dram_rd, wb_pc4, wb_ext,
      output stall_out, ex_valid, ex_rf_we, ex_mem_rd, ex_wd_sel, ex_wr,
             ex_rd1, ex_rd2, ex_ext, ex_pc, ex_pc4
   );
endinterface

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: immediate generator, register file with optional write-through bypass,
// write-back selector, load-use hazard detection and the ID/EX register with bubble/flush.
module id_stage_pipe #(
   parameter int XLEN    = 32,
   parameter int REG_NUM = 32,
   parameter int BYPASS  = 1
) (
   input  logic           clk,
   input  logic           rst,
   id_stage_pipe_if.slave bus
);
   localparam int AW = $clog2(REG_NUM);

   // Indices that do not exist in this register file (bit 4 set on RV32E) collapse to x0,
   // so they read 0, never match a hazard, and a destination there is written to x0.
   function automatic logic [AW-1:0] eff_idx(input logic [4:0] idx);
      logic [AW-1:0] r;
      r = idx[AW-1:0];
      if ((idx >> AW) != 5'd0) r = '0;
      return r;
   endfunction

   logic [AW-1:0]   rs1, rs2, rd;
   logic [31:0]     imm32;
   logic [XLEN-1:0] ext;
   logic [XLEN-1:0] wb_wd;
   logic [XLEN-1:0] rd1, rd2;
   logic            hazard;
   logic            load;

   logic [XLEN-1:0] rf_q [REG_NUM];

   logic            ex_valid_q,  ex_valid_d;
   logic            ex_rf_we_q,  ex_rf_we_d;
   logic            ex_mem_rd_q, ex_mem_rd_d;
   logic [1:0]      ex_wd_sel_q, ex_wd_sel_d;
   logic [AW-1:0]   ex_wr_q,     ex_wr_d;
   logic [XLEN-1:0] ex_rd1_q,    ex_rd1_d;
   logic [XLEN-1:0] ex_rd2_q,    ex_rd2_d;
   logic [XLEN-1:0] ex_ext_q,    ex_ext_d;
   logic [XLEN-1:0] ex_pc_q,     ex_pc_d;
   logic [XLEN-1:0] ex_pc4_q,    ex_pc4_d;

   assign rs1 = eff_idx(bus.if_inst[19:15]);
   assign rs2 = eff_idx(bus.if_inst[24:20]);
   assign rd  = eff_idx(bus.if_inst[11:7]);

   always_comb begin
      imm32 = '0;
      case (bus.sext_op)
         3'd0:    imm32 = {{20{bus.if_inst[31]}}, bus.if_inst[31:20]};
         3'd1:    imm32 = {{20{bus.if_inst[31]}}, bus.if_inst[31:25], bus.if_inst[11:7]};
         3'd2:    imm32 = {{19{bus.if_inst[31]}}, bus.if_inst[31], bus.if_inst[7],
                           bus.if_inst[30:25], bus.if_inst[11:8], 1'b0};
         3'd3:    imm32 = {bus.if_inst[31:12], 12'b0};
         3'd4:    imm32 = {{11{bus.if_inst[31]}}, bus.if_inst[31], bus.if_inst[19:12],
                           bus.if_inst[20], bus.if_inst[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   // Every format is already sign-extended to 32 bits; widen by sign for XLEN=64.
   assign ext = XLEN'($signed(imm32));

   always_comb begin
      wb_wd = bus.wb_alu_c;
      case (bus.wb_wd_sel)
         2'd0:    wb_wd = bus.wb_alu_c;
         2'd1:    wb_wd = bus.wb_dram_rd;
         2'd2:    wb_wd = bus.wb_pc4;
         default: wb_wd = bus.wb_ext;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) rf_q[i] <= '0;
      end else if (bus.wb_we && (bus.wb_wr != '0)) begin
         rf_q[bus.wb_wr] <= wb_wd;
      end
   end

   always_comb begin
      rd1 = rf_q[rs1];
      rd2 = rf_q[rs2];
      if (rs1 == '0) rd1 = '0;
      else if ((BYPASS != 0) && bus.wb_we && (bus.wb_wr == rs1)) rd1 = wb_wd;
      if (rs2 == '0) rd2 = '0;
      else if ((BYPASS != 0) && bus.wb_we && (bus.wb_wr == rs2)) rd2 = wb_wd;
   end

   assign hazard = ex_valid_q & ex_mem_rd_q & (ex_wr_q != '0) &
                   ((ex_wr_q == rs1) | (ex_wr_q == rs2)) & bus.if_valid;
   assign bus.stall_out = hazard & ~bus.flush;

   // Flush, hazard and an empty IF/ID all insert a bubble; only control bits are cleared.
   assign load = ~bus.flush & ~hazard & bus.if_valid;

   always_comb begin
      ex_valid_d  = load;
      ex_rf_we_d  = load & bus.rf_we_in;
      ex_mem_rd_d = load & bus.mem_rd_in;
      ex_wd_sel_d = bus.wd_sel_in;
      ex_wr_d     = rd;
      ex_rd1_d    = rd1;
      ex_rd2_d    = rd2;
      ex_ext_d    = ext;
      ex_pc_d     = bus.if_pc;
      ex_pc4_d    = bus.if_pc4;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q  <= 1'b0;
         ex_rf_we_q  <= 1'b0;
         ex_mem_rd_q <= 1'b0;
         ex_wd_sel_q <= '0;
         ex_wr_q     <= '0;
         ex_rd1_q    <= '0;
         ex_rd2_q    <= '0;
         ex_ext_q    <= '0;
         ex_pc_q     <= '0;
         ex_pc4_q    <= '0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_rf_we_q  <= ex_rf_we_d;
         ex_mem_rd_q <= ex_mem_rd_d;
         ex_wd_sel_q <= ex_wd_sel_d;
         ex_wr_q     <= ex_wr_d;
         ex_rd1_q    <= ex_rd1_d;
         ex_rd2_q    <= ex_rd2_d;
         ex_ext_q    <= ex_ext_d;
         ex_pc_q     <= ex_pc_d;
         ex_pc4_q    <= ex_pc4_d;
      end
   end

   assign bus.ex_valid  = ex_valid_q;
   assign bus.ex_rf_we  = ex_rf_we_q;
   assign bus.ex_mem_rd = ex_mem_rd_q;
   assign bus.ex_wd_sel = ex_wd_sel_q;
   assign bus.ex_wr     = ex_wr_q;
   assign bus.ex_rd1    = ex_rd1_q;
   assign bus.ex_rd2    = ex_rd2_q;
   assign bus.ex_ext    = ex_ext_q;
   assign bus.ex_pc     = ex_pc_q;
   assign bus.ex_pc4    = ex_pc4_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: bypass and non-bypass 32-bit instances share stimulus,
// a third RV32E/XLEN=64 instance covers the narrow register file and 64-bit immediates.
module tb_id_stage_pipe;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   id_stage_pipe_if #(.XLEN(32), .AW(5)) bus_a ();
   id_stage_pipe_if #(.XLEN(32), .AW(5)) bus_b ();
   id_stage_pipe_if #(.XLEN(64), .AW(4)) bus_c ();

   id_stage_pipe #(.XLEN(32), .REG_NUM(32), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   id_stage_pipe #(.XLEN(32), .REG_NUM(32), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
   id_stage_pipe #(.XLEN(64), .REG_NUM(16), .BYPASS(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Decode inputs to the two 32-bit instances.
   task automatic set_dec(input logic v, input logic [31:0] inst, input logic [2:0] sx,
                          input logic we, input logic mr, input logic [1:0] ws);
      bus_a.if_valid = v;  bus_b.if_valid = v;
      bus_a.if_inst = inst; bus_b.if_inst = inst;
      bus_a.sext_op = sx;  bus_b.sext_op = sx;
      bus_a.rf_we_in = we; bus_b.rf_we_in = we;
      bus_a.mem_rd_in = mr; bus_b.mem_rd_in = mr;
      bus_a.wd_sel_in = ws; bus_b.wd_sel_in = ws;
   endtask

   task automatic set_wb(input logic we, input logic [4:0] wr, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] dram,
                         input logic [31:0] pc4, input logic [31:0] ext);
      bus_a.wb_we = we;  bus_b.wb_we = we;
      bus_a.wb_wr = wr;  bus_b.wb_wr = wr;
      bus_a.wb_wd_sel = sel; bus_b.wb_wd_sel = sel;
      bus_a.wb_alu_c = alu;  bus_b.wb_alu_c = alu;
      bus_a.wb_dram_rd = dram; bus_b.wb_dram_rd = dram;
      bus_a.wb_pc4 = pc4; bus_b.wb_pc4 = pc4;
      bus_a.wb_ext = ext; bus_b.wb_ext = ext;
   endtask

   task automatic set_flush(input logic f);
      bus_a.flush = f;
      bus_b.flush = f;
   endtask

   logic [31:0] imm_inst [7];
   logic [2:0]  imm_op   [7];
   logic [31:0] imm_exp  [7];
   logic [31:0] sel_val  [4];

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      set_dec(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 2'd0);
      set_wb(1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      set_flush(1'b0);
      bus_a.if_pc = 32'h100; bus_a.if_pc4 = 32'h104;
      bus_b.if_pc = 32'h100; bus_b.if_pc4 = 32'h104;
      bus_c.if_valid = 1'b0; bus_c.if_inst = 32'h0; bus_c.if_pc = 64'h0; bus_c.if_pc4 = 64'h4;
      bus_c.sext_op = 3'd0; bus_c.rf_we_in = 1'b0; bus_c.mem_rd_in = 1'b0; bus_c.wd_sel_in = 2'd0;
      bus_c.flush = 1'b0; bus_c.wb_we = 1'b0; bus_c.wb_wr = 4'd0; bus_c.wb_wd_sel = 2'd0;
      bus_c.wb_alu_c = 64'h0; bus_c.wb_dram_rd = 64'h0; bus_c.wb_pc4 = 64'h0; bus_c.wb_ext = 64'h0;

      imm_inst[0] = 32'hFFF00093; imm_op[0] = 3'd0; imm_exp[0] = 32'hFFFFFFFF;
      imm_inst[1] = 32'hFE112E23; imm_op[1] = 3'd1; imm_exp[1] = 32'hFFFFFFFC;
      imm_inst[2] = 32'hFE000FE3; imm_op[2] = 3'd2; imm_exp[2] = 32'hFFFFFFFE;
      imm_inst[3] = 32'h12345037; imm_op[3] = 3'd3; imm_exp[3] = 32'h12345000;
      imm_inst[4] = 32'h0050106F; imm_op[4] = 3'd4; imm_exp[4] = 32'h00001804;
      imm_inst[5] = 32'hFFF00093; imm_op[5] = 3'd5; imm_exp[5] = 32'h00000000;
      imm_inst[6] = 32'h7FF00093; imm_op[6] = 3'd0; imm_exp[6] = 32'h000007FF;
      sel_val[0] = 32'h11; sel_val[1] = 32'h22; sel_val[2] = 32'h33; sel_val[3] = 32'h44;

      // Reset with a write-back to x5 and a valid reader of x5 pending.
      set_wb(1'b1, 5'd5, 2'd0, 32'hAAAA5555, 32'h0, 32'h0, 32'h0);
      set_dec(1'b1, 32'h00028093, 3'd0, 1'b1, 1'b0, 2'd0);
      #2;
      check("rst_ex_valid_a", 64'(bus_a.ex_valid), 64'h0);
      tick();
      tick();
      check("rst_ex_valid_a2", 64'(bus_a.ex_valid), 64'h0);
      check("rst_ex_wr_a", 64'(bus_a.ex_wr), 64'h0);
      check("rst_ex_rd1_a", 64'(bus_a.ex_rd1), 64'h0);
      check("rst_ex_ext_a", 64'(bus_a.ex_ext), 64'h0);
      check("rst_stall_a", 64'(bus_a.stall_out), 64'h0);
      check("rst_ex_valid_b", 64'(bus_b.ex_valid), 64'h0);
      check("rst_ex_valid_c", 64'(bus_c.ex_valid), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      set_wb(1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      tick();
      check("post_rst_valid", 64'(bus_a.ex_valid), 64'h1);
      check("post_rst_x5", 64'(bus_a.ex_rd1), 64'h0);
      check("post_rst_wr", 64'(bus_a.ex_wr), 64'h1);

      for (int i = 0; i < 7; i++) begin
         set_dec(1'b1, imm_inst[i], imm_op[i], 1'b1, 1'b0, 2'd0);
         tick();
         check($sformatf("imm_%0d", i), 64'(bus_a.ex_ext), 64'(imm_exp[i]));
      end

      // Same-cycle write-back to x3 while reading x3.
      set_wb(1'b1, 5'd3, 2'd0, 32'h1234, 32'h0, 32'h0, 32'h0);
      set_dec(1'b1, 32'h00018213, 3'd0, 1'b1, 1'b0, 2'd0);
      tick();
      check("bypass_a_rd1", 64'(bus_a.ex_rd1), 64'h1234);
      check("nobypass_b_rd1", 64'(bus_b.ex_rd1), 64'h0);
      set_wb(1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      tick();
      check("reissue_a_rd1", 64'(bus_a.ex_rd1), 64'h1234);
      check("reissue_b_rd1", 64'(bus_b.ex_rd1), 64'h1234);

      // Write-back source select, read on rs2.
      set_dec(1'b1, 32'h00600433, 3'd0, 1'b1, 1'b0, 2'd0);
      for (int s = 0; s < 4; s++) begin
         set_wb(1'b1, 5'd6, 2'(s), 32'h11, 32'h22, 32'h33, 32'h44);
         tick();
         check($sformatf("wdsel_a_%0d", s), 64'(bus_a.ex_rd2), 64'(sel_val[s]));
         check($sformatf("wdsel_b_%0d", s), 64'(bus_b.ex_rd2), (s == 0) ? 64'h0 : 64'(sel_val[s-1]));
      end

      // Writes to x0 are dropped, including the bypass path.
      set_wb(1'b1, 5'd0, 2'd0, 32'hDEAD, 32'h0, 32'h0, 32'h0);
      set_dec(1'b1, 32'h00000013, 3'd0, 1'b1, 1'b0, 2'd0);
      tick();
      check("x0_same_cycle_a", 64'(bus_a.ex_rd1), 64'h0);
      set_wb(1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      tick();
      check("x0_read_a", 64'(bus_a.ex_rd1), 64'h0);
      check("x0_read_b", 64'(bus_b.ex_rd1), 64'h0);

      // Load x7 then a reader of x7.
      bus_a.if_pc = 32'h200; bus_a.if_pc4 = 32'h204;
      set_dec(1'b1, 32'h0000A383, 3'd0, 1'b1, 1'b1, 2'd1);
      tick();
      check("ld_mem_rd", 64'(bus_a.ex_mem_rd), 64'h1);
      check("ld_wr", 64'(bus_a.ex_wr), 64'h7);
      check("ld_wd_sel", 64'(bus_a.ex_wd_sel), 64'h1);
      check("ld_pc", 64'(bus_a.ex_pc), 64'h200);
      check("ld_pc4", 64'(bus_a.ex_pc4), 64'h204);
      set_dec(1'b1, 32'h00710433, 3'd0, 1'b1, 1'b0, 2'd0);
      #1;
      check("lu_stall_a", 64'(bus_a.stall_out), 64'h1);
      check("lu_stall_b", 64'(bus_b.stall_out), 64'h1);
      tick();
      check("lu_bubble_valid", 64'(bus_a.ex_valid), 64'h0);
      check("lu_bubble_rf_we", 64'(bus_a.ex_rf_we), 64'h0);
      check("lu_stall_clear", 64'(bus_a.stall_out), 64'h0);
      tick();
      check("lu_issue_valid", 64'(bus_a.ex_valid), 64'h1);
      check("lu_issue_wr", 64'(bus_a.ex_wr), 64'h8);

      // Load to x0 never stalls.
      set_dec(1'b1, 32'h0000A003, 3'd0, 1'b1, 1'b1, 2'd1);
      tick();
      set_dec(1'b1, 32'h00000093, 3'd0, 1'b1, 1'b0, 2'd0);
      #1;
      check("ld_x0_stall", 64'(bus_a.stall_out), 64'h0);
      tick();
      check("ld_x0_valid", 64'(bus_a.ex_valid), 64'h1);

      // Flush beats a simultaneous load-use hazard.
      set_dec(1'b1, 32'h0000A383, 3'd0, 1'b1, 1'b1, 2'd1);
      tick();
      set_dec(1'b1, 32'h00710433, 3'd0, 1'b1, 1'b0, 2'd0);
      set_flush(1'b1);
      #1;
      check("flush_stall", 64'(bus_a.stall_out), 64'h0);
      tick();
      check("flush_valid", 64'(bus_a.ex_valid), 64'h0);
      set_flush(1'b0);

      // Empty IF/ID makes a bubble.
      set_dec(1'b0, 32'h00000093, 3'd0, 1'b1, 1'b0, 2'd0);
      tick();
      check("idle_valid", 64'(bus_a.ex_valid), 64'h0);
      check("idle_rf_we", 64'(bus_a.ex_rf_we), 64'h0);

      // Reset asserted in the middle of a stall.
      set_dec(1'b1, 32'h0000A383, 3'd0, 1'b1, 1'b1, 2'd1);
      tick();
      set_dec(1'b1, 32'h00710433, 3'd0, 1'b1, 1'b0, 2'd0);
      #1;
      check("rs_stall_before", 64'(bus_a.stall_out), 64'h1);
      rst = 1'b1;
      #1;
      check("rs_ex_valid", 64'(bus_a.ex_valid), 64'h0);
      check("rs_ex_mem_rd", 64'(bus_a.ex_mem_rd), 64'h0);
      check("rs_stall", 64'(bus_a.stall_out), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("rs_first_valid", 64'(bus_a.ex_valid), 64'h1);
      check("rs_first_wr", 64'(bus_a.ex_wr), 64'h8);
      set_dec(1'b1, 32'h00018213, 3'd0, 1'b1, 1'b0, 2'd0);
      tick();
      check("rs_x3_cleared_a", 64'(bus_a.ex_rd1), 64'h0);
      check("rs_x3_cleared_b", 64'(bus_b.ex_rd1), 64'h0);

      // RV32E, XLEN=64 instance.
      bus_c.if_valid = 1'b1;
      bus_c.if_inst = 32'h800000B7;
      bus_c.sext_op = 3'd3;
      bus_c.wb_we = 1'b1; bus_c.wb_wr = 4'd1; bus_c.wb_wd_sel = 2'd0;
      bus_c.wb_alu_c = 64'h0123456789ABCDEF;
      tick();
      check("c_u_ext", bus_c.ex_ext, 64'hFFFFFFFF80000000);
      check("c_u_wr", 64'(bus_c.ex_wr), 64'h1);
      bus_c.wb_we = 1'b0;
      bus_c.if_inst = 32'h001888B3;
      bus_c.sext_op = 3'd0;
      tick();
      check("c_x17_read", bus_c.ex_rd1, 64'h0);
      check("c_x1_read", bus_c.ex_rd2, 64'h0123456789ABCDEF);
      check("c_x17_dest", 64'(bus_c.ex_wr), 64'h0);
      bus_c.if_inst = 32'hFFF00093;
      tick();
      check("c_i_ext", bus_c.ex_ext, 64'hFFFFFFFFFFFFFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
